// File: rtl/dvi_stimulate_pkg.sv
// Shared timing defaults, FSM state type and colour-bar table
// for the DVI/VGA bring-up pattern source.
package dvi_stimulate_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF
                              + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF
                              + V_SYNC_DEF + V_BP_DEF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // {R,G,B} on/off mask per bar, left to right
  function automatic logic [2:0] bar_rgb(
    input logic [2:0] bar
  );
    logic [2:0] m;
    unique case (bar)
      3'd0:    m = 3'b111;
      3'd1:    m = 3'b110;
      3'd2:    m = 3'b011;
      3'd3:    m = 3'b010;
      3'd4:    m = 3'b101;
      3'd5:    m = 3'b100;
      3'd6:    m = 3'b001;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dvi_stimulate_if.sv
// Pixel/sync bus from the pattern source to the DVI encoder.
// master drives red/green/blue/hsync/vsync, slave observes.
interface dvi_stimulate_if;

  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       hsync;
  logic       vsync;

  modport master (
    output red, green, blue,
    output hsync, vsync
  );

  modport slave (
    input red, green, blue,
    input hsync, vsync
  );

endinterface

// File: rtl/dvi_timing_gen.sv
// Raster counters, IDLE/RUN control, sync and active decode.
// Ports: clock, reset (async low), start in; run/h_cnt/hs_on/vs_on/active out.
module dvi_timing_gen
  import dvi_stimulate_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic          run,
  output logic [HW-1:0] h_cnt,
  output logic          hs_on,
  output logic          vs_on,
  output logic          active
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  state_t          state;
  logic [VW-1:0]   v_cnt;

  // Counters stay at 0 through the IDLE->RUN edge, so the
  // first RUN cycle presents h=v=0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) state <= RUN;
        end
        RUN: begin
          if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) v_cnt <= '0;
            else                 v_cnt <= v_cnt + 1'b1;
          end else begin
            h_cnt <= h_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign run    = (state == RUN);
  assign hs_on  = (h_cnt >= H_SS) && (h_cnt < H_SE);
  assign vs_on  = (v_cnt >= V_SS) && (v_cnt < V_SE);
  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);

endmodule

// File: rtl/dvi_stimulate.sv
// Colour-bar test pattern source: 8 vertical bars plus raster sync.
// Ports: clock, reset (async low), start in; vid (master) pixel/sync bus out.
module dvi_stimulate
  import dvi_stimulate_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  dvi_stimulate_if.master vid
);

  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int BW = H_ACTIVE / 8;

  logic          run;
  logic [HW-1:0] h_cnt;
  logic          hs_on;
  logic          vs_on;
  logic          active;
  logic [2:0]    bar;
  logic [2:0]    mask;

  dvi_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HW       (HW),
    .VW       (VW)
  ) u_tim (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .run    (run),
    .h_cnt  (h_cnt),
    .hs_on  (hs_on),
    .vs_on  (vs_on),
    .active (active)
  );

  // Bar index by threshold compare; scanning down leaves the
  // lowest bar whose upper edge lies above h_cnt.
  always_comb begin
    bar = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if (h_cnt < HW'((i + 1) * BW)) bar = 3'(i);
    end
  end

  assign mask = bar_rgb(bar);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vid.red   <= 8'h00;
      vid.green <= 8'h00;
      vid.blue  <= 8'h00;
      vid.hsync <= ~SYNC_POL;
      vid.vsync <= ~SYNC_POL;
    end else if (run) begin
      vid.red   <= {8{active & mask[2]}};
      vid.green <= {8{active & mask[1]}};
      vid.blue  <= {8{active & mask[0]}};
      vid.hsync <= hs_on ? SYNC_POL : ~SYNC_POL;
      vid.vsync <= vs_on ? SYNC_POL : ~SYNC_POL;
    end else begin
      vid.red   <= 8'h00;
      vid.green <= 8'h00;
      vid.blue  <= 8'h00;
      vid.hsync <= ~SYNC_POL;
      vid.vsync <= ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_dvi_stimulate.sv
// Bench for dvi_stimulate: default 640x480 build plus a tiny
// SYNC_POL=1 raster so whole frames fit in a short run.
module tb_dvi_stimulate;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  dvi_stimulate_if vd ();
  dvi_stimulate_if vs ();

  dvi_stimulate u_dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .vid   (vd)
  );

  dvi_stimulate #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (2),
    .SYNC_POL (1'b1)
  ) u_small (
    .clock (clock),
    .reset (reset),
    .start (start),
    .vid   (vs)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  bit [2:0] bar_tbl [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                            3'b101, 3'b100, 3'b001, 3'b000};

  function automatic logic [25:0] exp_px(
    input bit run, input int h, input int v,
    input int ha, input int hfp, input int hsw,
    input int va, input int vfp, input int vsw,
    input bit pol);
    logic [7:0] r, g, b;
    logic       hs, vv;
    bit   [2:0] m;
    if (!run) return {24'h0, ~pol, ~pol};
    m  = bar_tbl[h / (ha / 8)];
    r  = (h < ha && v < va && m[2]) ? 8'hFF : 8'h00;
    g  = (h < ha && v < va && m[1]) ? 8'hFF : 8'h00;
    b  = (h < ha && v < va && m[0]) ? 8'hFF : 8'h00;
    hs = (h >= ha + hfp && h < ha + hfp + hsw) ? pol : ~pol;
    vv = (v >= va + vfp && v < va + vfp + vsw) ? pol : ~pol;
    return {r, g, b, hs, vv};
  endfunction

  logic [25:0] qd[$];
  logic [25:0] qs[$];

  bit dr = 0; int dh = 0; int dv = 0;
  bit sr = 0; int sh = 0; int sv = 0;

  // Reference rasters: expected output of each edge is pushed
  // from the pre-edge model state, then the model steps.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      dr = 0; dh = 0; dv = 0; qd.delete();
      sr = 0; sh = 0; sv = 0; qs.delete();
    end else begin
      qd.push_back(exp_px(dr, dh, dv, 640, 16, 96,
                          480, 10, 2, 1'b0));
      qs.push_back(exp_px(sr, sh, sv, 16, 2, 3,
                          8, 1, 2, 1'b1));
      if (!dr) dr = start;
      else begin
        dh++;
        if (dh == 800) begin dh = 0; dv++; end
        if (dv == 525) dv = 0;
      end
      if (!sr) sr = start;
      else begin
        sh++;
        if (sh == 24) begin sh = 0; sv++; end
        if (sv == 13) sv = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (qd.size() > 0)
      chk("px_def", 32'({vd.red, vd.green, vd.blue,
                         vd.hsync, vd.vsync}), 32'(qd.pop_front()));
    if (qs.size() > 0)
      chk("px_small", 32'({vs.red, vs.green, vs.blue,
                           vs.hsync, vs.vsync}), 32'(qs.pop_front()));
  end

  task automatic chk_rst(input string tag);
    chk({tag, "_def"}, 32'({vd.red, vd.green, vd.blue,
                            vd.hsync, vd.vsync}), 32'h3);
    chk({tag, "_small"}, 32'({vs.red, vs.green, vs.blue,
                              vs.hsync, vs.vsync}), 32'h0);
  endtask

  // Called on the negedge after the start edge: the k-th next
  // negedge shows output pixel k-1.
  task automatic meas_h(input bit full);
    int n, m, k;
    n = 0;
    while (vd.hsync !== 1'b0 && n < 2000) begin
      @(negedge clock); n++;
    end
    chk("hs_first", 32'(n - 1), 32'd656);
    if (full) begin
      m = 0;
      while (vd.hsync === 1'b0 && m < 1000) begin
        @(negedge clock); m++;
      end
      chk("hs_width", 32'(m), 32'd96);
      k = 0;
      while (vd.hsync !== 1'b0 && k < 1000) begin
        @(negedge clock); k++;
      end
      chk("hs_period", 32'(m + k), 32'd800);
    end
  endtask

  task automatic meas_v(input bit full);
    int n, m, k;
    n = 0;
    while (vs.vsync !== 1'b1 && n < 1000) begin
      @(negedge clock); n++;
    end
    chk("vs_first", 32'(n - 1), 32'd216);
    if (full) begin
      m = 0;
      while (vs.vsync === 1'b1 && m < 1000) begin
        @(negedge clock); m++;
      end
      chk("vs_width", 32'(m), 32'd48);
      k = 0;
      while (vs.vsync !== 1'b1 && k < 1000) begin
        @(negedge clock); k++;
      end
      chk("vs_period", 32'(m + k), 32'd312);
    end
  endtask

  task automatic kick(input bit full);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    fork
      meas_h(full);
      meas_v(full);
    join
  endtask

  initial begin
    #12;
    chk_rst("rst_hold");
    @(negedge clock); reset = 1'b1;
    repeat (2000) @(negedge clock);
    chk_rst("idle");
    kick(1'b1);
    repeat (1500) @(negedge clock);
    #2 reset = 1'b0;
    #1 chk_rst("rst_async");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    chk_rst("idle2");
    kick(1'b0);
    repeat (500) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
